instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 193 +++++++++++++++++++
 tb/tb_instruction_fetch.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch
//   Fetches one 16-bit instruction word per request from the instruction memory.
//   It holds the word in an instruction register and decodes the register
//   fields and the sign-extended immediate from that register.
//
// Build option
//   FETCH_TIMEOUT_EN : when defined, a fetch is abandoned after TIMEOUT mem_req
//                      cycles without mem_ack. The FSM then enters ERR and
//                      raises fetch_err. When undefined, REQ waits indefinitely
//                      and fetch_err is tied low.
//
// Ports
//   clk         : clock; all state changes on the rising edge
//   reset       : asynchronous, active-low reset
//   pc          : fetch address from the control stage (13 bits)
//   read_flag   : fetch request level from the control stage
//   mem_addr    : instruction memory word address (registered)
//   mem_req     : memory read request (registered)
//   mem_ack     : memory acknowledge; mem_rdata is valid in the same cycle
//   mem_rdata   : instruction word from memory
//   instr       : instruction register
//   opcode/rd/rs1/rs2 : instr[15:13] / [12:10] / [9:7] / [6:4]
//   imm         : instr[6:0] sign-extended to 16 bits
//   instr_valid : instr holds the word for the current request
//   fetch_busy  : high while a request is outstanding (state REQ)
//   fetch_err   : last fetch timed out
module instruction_fetch #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [12:0] pc,
  input  logic        read_flag,
  output logic [12:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] instr,
  output logic [2:0]  opcode,
  output logic [2:0]  rd,
  output logic [2:0]  rs1,
  output logic [2:0]  rs2,
  output logic [15:0] imm,
  output logic        instr_valid,
  output logic        fetch_busy,
  output logic        fetch_err
);

  // A zero timeout would abandon every fetch before an ack could land.
  if (TIMEOUT < 1) begin : g_timeout_range
    $error("instruction_fetch: TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    DONE  = 3'd2,
    DRAIN = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [12:0] mem_addr_r, mem_addr_s;
  logic        mem_req_r, mem_req_s;
  logic [15:0] instr_r, instr_s;
  logic        instr_valid_r, instr_valid_s;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] tmo_cnt_r, tmo_cnt_s;
  logic             fetch_err_r, fetch_err_s;
`endif

  // Next-state and next-register-value logic for the fetch FSM
  always_comb begin
    state_s       = state_r;
    mem_addr_s    = mem_addr_r;
    mem_req_s     = mem_req_r;
    instr_s       = instr_r;
    instr_valid_s = instr_valid_r;
`ifdef FETCH_TIMEOUT_EN
    tmo_cnt_s     = tmo_cnt_r;
    fetch_err_s   = fetch_err_r;
`endif
    case (state_r)
      IDLE: begin
        if (read_flag) begin
          mem_addr_s    = pc;
          mem_req_s     = 1'b1;
          instr_valid_s = 1'b0;
          state_s       = REQ;
`ifdef FETCH_TIMEOUT_EN
          tmo_cnt_s     = CNT_W'(0);
          fetch_err_s   = 1'b0;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (mem_ack) begin
          mem_req_s = 1'b0;
          if (read_flag) begin
            instr_s       = mem_rdata;
            instr_valid_s = 1'b1;
            state_s       = DONE;
          end else begin
            // Request withdrawn: the returning word is discarded.
            state_s = IDLE;
          end
        end
`ifdef FETCH_TIMEOUT_EN
        else if (tmo_cnt_r == CNT_W'(TIMEOUT - 1)) begin
          tmo_cnt_s     = CNT_W'(TIMEOUT);
          mem_req_s     = 1'b0;
          fetch_err_s   = 1'b1;
          instr_valid_s = 1'b0;
          state_s       = ERR;
        end else begin
          tmo_cnt_s = tmo_cnt_r + CNT_W'(1);
        end
`else
        else begin
          state_s = REQ;
        end
`endif
      end
      DONE: begin
        if (!read_flag) begin
          state_s = DRAIN;
        end else begin
          state_s = DONE;
        end
      end
      DRAIN: begin
        state_s = IDLE;
      end
      ERR: begin
        if (!read_flag) begin
          state_s = IDLE;
        end else begin
          state_s = ERR;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      mem_addr_r    <= 13'd0;
      mem_req_r     <= 1'b0;
      instr_r       <= 16'h0000;
      instr_valid_r <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      tmo_cnt_r     <= CNT_W'(0);
      fetch_err_r   <= 1'b0;
`endif
    end else begin
      state_r       <= state_s;
      mem_addr_r    <= mem_addr_s;
      mem_req_r     <= mem_req_s;
      instr_r       <= instr_s;
      instr_valid_r <= instr_valid_s;
`ifdef FETCH_TIMEOUT_EN
      tmo_cnt_r     <= tmo_cnt_s;
      fetch_err_r   <= fetch_err_s;
`endif
    end
  end

  assign mem_addr    = mem_addr_r;
  assign mem_req     = mem_req_r;
  assign instr       = instr_r;
  assign instr_valid = instr_valid_r;
  assign fetch_busy  = (state_r == REQ);
`ifdef FETCH_TIMEOUT_EN
  assign fetch_err   = fetch_err_r;
`else
  assign fetch_err   = 1'b0;
`endif

  assign opcode = instr_r[15:13];
  assign rd     = instr_r[12:10];
  assign rs1    = instr_r[9:7];
  assign rs2    = instr_r[6:4];
  assign imm    = {{9{instr_r[6]}}, instr_r[6:0]};

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a table of fetch vectors driven
// through a scoreboard, followed by hand-written withdraw, reset and timeout
// sequences.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] pc;
  logic        read_flag;
  logic [12:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] instr;
  logic [2:0]  opcode, rd, rs1, rs2;
  logic [15:0] imm;
  logic        instr_valid, fetch_busy, fetch_err;

  instruction_fetch #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .pc(pc), .read_flag(read_flag),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .instr(instr), .opcode(opcode), .rd(rd),
    .rs1(rs1), .rs2(rs2), .imm(imm), .instr_valid(instr_valid),
    .fetch_busy(fetch_busy), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] pc;
    logic [12:0] pc_mid;
    logic [15:0] rdata;
    int          delay;
    logic [2:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [15:0] imm;
  } vec_t;

  vec_t vecs[5];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input vec_t v);
    vec_t e;
    sb.push_back(v);
    pc = v.pc;
    read_flag = 1'b1;
    mem_ack = 1'b0;
    tick;
    chk("req_rise", {31'd0, mem_req}, 32'd1);
    chk("req_addr", {19'd0, mem_addr}, {19'd0, v.pc});
    chk("req_busy", {31'd0, fetch_busy}, 32'd1);
    chk("req_valid_clr", {31'd0, instr_valid}, 32'd0);
    pc = v.pc_mid;
    for (int i = 0; i < v.delay; i++) begin
      tick;
      chk("wait_req", {31'd0, mem_req}, 32'd1);
      chk("wait_addr", {19'd0, mem_addr}, {19'd0, v.pc});
    end
    mem_ack = 1'b1;
    mem_rdata = v.rdata;
    tick;
    mem_ack = 1'b0;
    chk("ack_req_drop", {31'd0, mem_req}, 32'd0);
    chk("ack_busy", {31'd0, fetch_busy}, 32'd0);
    chk("ack_valid", {31'd0, instr_valid}, 32'd1);
    e = sb.pop_front();
    chk("instr", {16'd0, instr}, {16'd0, e.rdata});
    chk("opcode", {29'd0, opcode}, {29'd0, e.op});
    chk("rd", {29'd0, rd}, {29'd0, e.rd});
    chk("rs1", {29'd0, rs1}, {29'd0, e.rs1});
    chk("rs2", {29'd0, rs2}, {29'd0, e.rs2});
    chk("imm", {16'd0, imm}, {16'd0, e.imm});
    // stray ack while in DONE must not disturb the held word
    mem_ack = 1'b1;
    mem_rdata = 16'h0BAD;
    tick;
    mem_ack = 1'b0;
    chk("done_hold", {16'd0, instr}, {16'd0, e.rdata});
    chk("done_valid", {31'd0, instr_valid}, 32'd1);
    read_flag = 1'b0;
    tick;
    chk("drain_valid", {31'd0, instr_valid}, 32'd1);
    chk("drain_instr", {16'd0, instr}, {16'd0, e.rdata});
    tick;
    chk("idle_valid", {31'd0, instr_valid}, 32'd1);
    chk("idle_busy", {31'd0, fetch_busy}, 32'd0);
    chk("idle_addr", {19'd0, mem_addr}, {19'd0, v.pc});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] last_instr;
    int n;
    reset = 1'b0;
    pc = 13'd0;
    read_flag = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = 16'h0000;

    // reset state, before any clock edge
    #2;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr", {19'd0, mem_addr}, 32'd0);
    chk("rst_instr", {16'd0, instr}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    chk("rst_busy", {31'd0, fetch_busy}, 32'd0);
    chk("rst_imm", {16'd0, imm}, 32'd0);
    #10;
    reset = 1'b1;
    tick;
    chk("idle_noreq", {31'd0, mem_req}, 32'd0);

    vecs[0] = '{13'h0005, 13'h0005, 16'h2C85, 0, 3'd1, 3'd3, 3'd1, 3'd0, 16'h0005};
    vecs[1] = '{13'h1FFF, 13'h1FFF, 16'h4A7F, 2, 3'd2, 3'd2, 3'd4, 3'd7, 16'hFFFF};
    vecs[2] = '{13'h0005, 13'h0009, 16'h2C85, 5, 3'd1, 3'd3, 3'd1, 3'd0, 16'h0005};
    vecs[3] = '{13'h0000, 13'h0000, 16'hE03A, 1, 3'd7, 3'd0, 3'd0, 3'd3, 16'h003A};
    vecs[4] = '{13'h0A5A, 13'h0A5A, 16'h1F40, 3, 3'd0, 3'd7, 3'd6, 3'd4, 16'hFFC0};
    for (int i = 0; i < 5; i++) begin
      do_fetch(vecs[i]);
    end
    last_instr = 16'h1F40;

    // request withdrawn while waiting, then ack arrives
    pc = 13'h0007;
    read_flag = 1'b1;
    tick;
    chk("wd_busy", {31'd0, fetch_busy}, 32'd1);
    chk("wd_valid_clr", {31'd0, instr_valid}, 32'd0);
    read_flag = 1'b0;
    tick;
    chk("wd_still_req", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1;
    mem_rdata = 16'hFFFF;
    tick;
    mem_ack = 1'b0;
    chk("wd_instr_kept", {16'd0, instr}, {16'd0, last_instr});
    chk("wd_valid", {31'd0, instr_valid}, 32'd0);
    chk("wd_req", {31'd0, mem_req}, 32'd0);
    chk("wd_idle", {31'd0, fetch_busy}, 32'd0);
    // ack in IDLE is ignored
    mem_ack = 1'b1;
    mem_rdata = 16'h1234;
    tick;
    mem_ack = 1'b0;
    chk("idle_ack_instr", {16'd0, instr}, {16'd0, last_instr});
    chk("idle_ack_req", {31'd0, mem_req}, 32'd0);
    chk("idle_ack_busy", {31'd0, fetch_busy}, 32'd0);
    chk("idle_ack_addr", {19'd0, mem_addr}, 32'h7);

    // reset pulsed between edges while a request is outstanding
    pc = 13'h0003;
    read_flag = 1'b1;
    tick;
    chk("mr_req", {31'd0, mem_req}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mr_req_clr", {31'd0, mem_req}, 32'd0);
    chk("mr_instr_clr", {16'd0, instr}, 32'd0);
    chk("mr_addr_clr", {19'd0, mem_addr}, 32'd0);
    chk("mr_busy_clr", {31'd0, fetch_busy}, 32'd0);
    #1;
    reset = 1'b1;
    read_flag = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 16'h5555;
    tick;
    mem_ack = 1'b0;
    chk("mr_late_instr", {16'd0, instr}, 32'd0);
    chk("mr_late_valid", {31'd0, instr_valid}, 32'd0);
    chk("mr_late_req", {31'd0, mem_req}, 32'd0);
    chk("mr_late_busy", {31'd0, fetch_busy}, 32'd0);

`ifdef FETCH_TIMEOUT_EN
    pc = 13'h0011;
    read_flag = 1'b1;
    tick;
    n = 0;
    while (mem_req === 1'b1 && n < 40) begin
      tick;
      n++;
    end
    chk("tmo_cycles", n, 32'd16);
    chk("tmo_err", {31'd0, fetch_err}, 32'd1);
    chk("tmo_valid", {31'd0, instr_valid}, 32'd0);
    chk("tmo_busy", {31'd0, fetch_busy}, 32'd0);
    tick;
    chk("err_hold", {31'd0, fetch_err}, 32'd1);
    read_flag = 1'b0;
    tick;
    chk("err_idle", {31'd0, fetch_err}, 32'd1);
    read_flag = 1'b1;
    pc = 13'h0012;
    tick;
    chk("err_clear", {31'd0, fetch_err}, 32'd0);
    chk("err_newreq", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1;
    mem_rdata = 16'h4A7F;
    tick;
    mem_ack = 1'b0;
    chk("err_refetch", {16'd0, instr}, 32'h4A7F);
    read_flag = 1'b0;
    tick;
    tick;
`else
    pc = 13'h0011;
    read_flag = 1'b1;
    tick;
    n = 0;
    repeat (40) begin
      tick;
      n++;
    end
    chk("nto_req", {31'd0, mem_req}, 32'd1);
    chk("nto_err", {31'd0, fetch_err}, 32'd0);
    chk("nto_busy", {31'd0, fetch_busy}, 32'd1);
    mem_ack = 1'b1;
    mem_rdata = 16'h4A7F;
    tick;
    mem_ack = 1'b0;
    chk("nto_valid", {31'd0, instr_valid}, 32'd1);
    chk("nto_instr", {16'd0, instr}, 32'h4A7F);
    read_flag = 1'b0;
    tick;
    tick;
`endif

    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
